// File: rtl/rom_read_arbiter_if.sv
// Request/response channels for two ROM readers plus the shared ROM read port.
// The slave modport is the arbiter side; the master modport is the requester/ROM side.
interface rom_read_arbiter_if #(
  parameter int ADDR_LEN = 3,
  parameter int DATA_LEN = 32
);
  logic                req0_valid;
  logic [ADDR_LEN-1:0] req0_idx;
  logic                req0_ready;
  logic                rsp0_valid;
  logic [DATA_LEN-1:0] rsp0_data;
  logic                rsp0_ready;

  logic                req1_valid;
  logic [ADDR_LEN-1:0] req1_idx;
  logic                req1_ready;
  logic                rsp1_valid;
  logic [DATA_LEN-1:0] rsp1_data;
  logic                rsp1_ready;

  logic [ADDR_LEN-1:0] rom_idx_o;
  logic [DATA_LEN-1:0] rom_data_i;

  modport slave (
    input  req0_valid, req0_idx, rsp0_ready,
    input  req1_valid, req1_idx, rsp1_ready,
    input  rom_data_i,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output rom_idx_o
  );

  modport master (
    output req0_valid, req0_idx, rsp0_ready,
    output req1_valid, req1_idx, rsp1_ready,
    output rom_data_i,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  rom_idx_o
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Two-port arbiter for one combinational ROM read port; response registered, valid the cycle after grant.
// Held response blocks new grants until its owner takes it; 1 read/cycle when consumed every cycle.
// ROM_READ_ARBITER_RR_EN selects round-robin on contention, otherwise port 0 has fixed priority.
module rom_read_arbiter #(
  parameter int ADDR_LEN = 3,
  parameter int DATA_LEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  rom_read_arbiter_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state, state_nxt;
  logic                rsp_own, rsp_own_nxt;
  logic [DATA_LEN-1:0] rsp_data, rsp_data_nxt;
  logic                last_gnt, last_gnt_nxt;

  logic rsp_vld;
  logic own_ready;
  logic slot_free;
  logic any_req;
  logic gnt;
  logic win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      rsp_own  <= 1'b0;
      rsp_data <= '0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      rsp_own  <= rsp_own_nxt;
      rsp_data <= rsp_data_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  assign rsp_vld   = (state == FULL);
  assign own_ready = rsp_own ? bus.rsp1_ready : bus.rsp0_ready;
  assign slot_free = !rsp_vld || own_ready;
  assign any_req   = bus.req0_valid || bus.req1_valid;
  // Gating with rst keeps a request presented during reset from being accepted.
  assign gnt       = slot_free && any_req && !rst;

`ifdef ROM_READ_ARBITER_RR_EN
  assign win = (bus.req0_valid && bus.req1_valid) ? !last_gnt : bus.req1_valid;
`else
  assign win = !bus.req0_valid;
`endif

  always_comb begin
    state_nxt     = state;
    rsp_own_nxt   = rsp_own;
    rsp_data_nxt  = rsp_data;
    last_gnt_nxt  = last_gnt;
    bus.rom_idx_o = '0;
    if (gnt) begin
      bus.rom_idx_o = win ? bus.req1_idx : bus.req0_idx;
      state_nxt     = FULL;
      rsp_data_nxt  = bus.rom_data_i;
      rsp_own_nxt   = win;
      last_gnt_nxt  = win;
    end else if (rsp_vld && own_ready) begin
      state_nxt = EMPTY;
    end
  end

  assign bus.req0_ready = gnt && !win;
  assign bus.req1_ready = gnt && win;
  assign bus.rsp0_valid = rsp_vld && !rsp_own;
  assign bus.rsp1_valid = rsp_vld && rsp_own;
  assign bus.rsp0_data  = rsp_data;
  assign bus.rsp1_data  = rsp_data;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed vector bench for rom_read_arbiter with a small ROM model; expectations depend on ROM_READ_ARBITER_RR_EN.
module tb_rom_read_arbiter;
  localparam int AL = 3;
  localparam int DL = 32;
`ifdef ROM_READ_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rom_read_arbiter_if #(.ADDR_LEN(AL), .DATA_LEN(DL)) bus ();

  rom_read_arbiter #(.ADDR_LEN(AL), .DATA_LEN(DL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] w(input int i);
    if (i == 2) return 32'hDEADBEEF;
    return 32'hA000_0000 | 32'(i);
  endfunction

  logic [31:0] rom_mem [8];
  assign bus.rom_data_i = rom_mem[bus.rom_idx_o];

  typedef struct {
    logic        rst;
    logic        v0;
    logic [2:0]  i0;
    logic        v1;
    logic [2:0]  i1;
    logic        r0;
    logic        r1;
    logic        e_rdy0;
    logic        e_rdy1;
    logic [2:0]  e_idx;
    logic        e_v0;
    logic        e_v1;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int r, v0, i0, v1, i1, r0, r1,
                              er0, er1, eidx, ev0, ev1, input logic [31:0] ed);
    vec_t t;
    t.rst = 1'(r);     t.v0 = 1'(v0);     t.i0 = 3'(i0);
    t.v1 = 1'(v1);     t.i1 = 3'(i1);     t.r0 = 1'(r0);
    t.r1 = 1'(r1);     t.e_rdy0 = 1'(er0); t.e_rdy1 = 1'(er1);
    t.e_idx = 3'(eidx); t.e_v0 = 1'(ev0); t.e_v1 = 1'(ev1);
    t.e_dat = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    bit got;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) rom_mem[i] = w(i);
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_idx = '0; bus.rsp0_ready = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_idx = '0; bus.rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);

    // rst v0 i0 v1 i1 r0 r1 | rdy0 rdy1 idx v0 v1 data
    vecs.push_back(mk(1,1,2,0,0,1,1, 0,0,0, 0,0, 32'h0));
    vecs.push_back(mk(0,1,2,0,0,1,1, 1,0,2, 0,0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,1,1, 0,0,0, 1,0, 32'hDEADBEEF));
    vecs.push_back(mk(0,0,0,1,0,1,1, 0,1,0, 0,0, 32'hDEADBEEF));
    vecs.push_back(mk(0,0,0,1,1,1,1, 0,1,1, 0,1, w(0)));
    vecs.push_back(mk(0,0,0,1,2,1,1, 0,1,2, 0,1, w(1)));
    vecs.push_back(mk(0,0,0,1,3,1,1, 0,1,3, 0,1, w(2)));
    vecs.push_back(mk(0,0,0,0,0,1,1, 0,0,0, 0,1, w(3)));
    // steady contention: RR alternates 0,1,0,1,0,1; fixed grants port 0 every time
    vecs.push_back(mk(0,1,4,1,5,1,1, 1,0,4, 0,0, w(3)));
    for (int k = 0; k < 5; k++) begin
      if (!RR)         vecs.push_back(mk(0,1,4,1,5,1,1, 1,0,4, 1,0, w(4)));
      else if (k % 2 == 0) vecs.push_back(mk(0,1,4,1,5,1,1, 0,1,5, 1,0, w(4)));
      else             vecs.push_back(mk(0,1,4,1,5,1,1, 1,0,4, 0,1, w(5)));
    end
    vecs.push_back(mk(0,0,0,0,0,1,1, 0,0,0, RR ? 0 : 1, RR ? 1 : 0, RR ? w(5) : w(4)));
    // back-pressure: port 0 response held 3 cycles while port 1 waits
    vecs.push_back(mk(0,1,6,0,0,0,1, 1,0,6, 0,0, RR ? w(5) : w(4)));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,0,0,1,7,0,1, 0,0,0, 1,0, w(6)));
    vecs.push_back(mk(0,0,0,1,7,1,1, 0,1,7, 1,0, w(6)));
    vecs.push_back(mk(0,0,0,0,0,1,1, 0,0,0, 0,1, w(7)));
    // reset with a response pending, then contention goes to port 0 first
    vecs.push_back(mk(0,1,2,0,0,0,1, 1,0,2, 0,0, w(7)));
    vecs.push_back(mk(1,0,0,1,3,0,1, 0,0,0, 1,0, 32'hDEADBEEF));
    vecs.push_back(mk(0,1,1,1,3,1,1, 1,0,1, 0,0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,1,1, 0,0,0, 1,0, w(1)));

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      rst            = vecs[n].rst;
      bus.req0_valid = vecs[n].v0;  bus.req0_idx = vecs[n].i0;
      bus.req1_valid = vecs[n].v1;  bus.req1_idx = vecs[n].i1;
      bus.rsp0_ready = vecs[n].r0;  bus.rsp1_ready = vecs[n].r1;
      #2;
      chk($sformatf("v%0d req0_ready", n), 32'(bus.req0_ready), 32'(vecs[n].e_rdy0));
      chk($sformatf("v%0d req1_ready", n), 32'(bus.req1_ready), 32'(vecs[n].e_rdy1));
      chk($sformatf("v%0d rom_idx", n),    32'(bus.rom_idx_o),  32'(vecs[n].e_idx));
      chk($sformatf("v%0d rsp0_valid", n), 32'(bus.rsp0_valid), 32'(vecs[n].e_v0));
      chk($sformatf("v%0d rsp1_valid", n), 32'(bus.rsp1_valid), 32'(vecs[n].e_v1));
      chk($sformatf("v%0d rsp0_data", n),  bus.rsp0_data,       vecs[n].e_dat);
      chk($sformatf("v%0d rsp1_data", n),  bus.rsp1_data,       vecs[n].e_dat);
    end

    // Port 0 holds its response; port 1 must be granted the cycle rsp0_ready rises.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_idx = 3'd3; bus.rsp0_ready = 1'b0;
    bus.req1_valid = 1'b0; bus.rsp1_ready = 1'b1;
    #2;
    chk("seq req0_ready", 32'(bus.req0_ready), 32'd1);
    got = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_idx = 3'd6;
      bus.rsp0_ready = (c >= 3);
      #2;
      if (c < 3) begin
        chk($sformatf("seq hold%0d rsp0_data", c), bus.rsp0_data, w(3));
        chk($sformatf("seq hold%0d req1_ready", c), 32'(bus.req1_ready), 32'd0);
      end
      if (bus.req1_ready) begin
        got = 1'b1;
        chk("seq grant cycle", 32'(c), 32'd3);
        break;
      end
    end
    chk("seq req1 granted within budget", 32'(got), 32'd1);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    #2;
    chk("seq rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    chk("seq rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    chk("seq rsp1_data",  bus.rsp1_data, w(6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
